// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between fetch and MEM-stage requesters.
// One outstanding transaction; data side has priority in IDLE.
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_data_ok,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_data_ok,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              stall_o
);

  typedef enum logic [2:0] {
    IDLE,
    D_ADDR,
    D_DATA,
    I_ADDR,
    I_DATA
  } state_t;

  typedef struct packed {
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } busReq_t;

  state_t  state, stateNext;
  busReq_t req, reqNext;
  logic    maskI, maskD;
  logic    instDone, dataDone;

  always_comb begin
    stateNext = state;
    reqNext   = req;
    instDone  = 1'b0;
    dataDone  = 1'b0;
    unique case (state)
      IDLE: begin
        if (data_req & ~maskD) begin
          reqNext.wr    = data_wr;
          reqNext.size  = data_size;
          reqNext.addr  = data_addr;
          reqNext.wdata = data_wdata;
          stateNext     = D_ADDR;
        end else if (inst_req & ~maskI) begin
          reqNext.wr    = 1'b0;
          reqNext.size  = 2'd2;
          reqNext.addr  = inst_addr;
          reqNext.wdata = '0;
          stateNext     = I_ADDR;
        end
      end
      D_ADDR: begin
        if (bus_addr_ok) begin
          // a zero-latency response skips the wait state
          if (bus_data_ok) begin
            dataDone  = 1'b1;
            stateNext = IDLE;
          end else begin
            stateNext = D_DATA;
          end
        end
      end
      D_DATA: begin
        if (bus_data_ok) begin
          dataDone  = 1'b1;
          stateNext = IDLE;
        end
      end
      I_ADDR: begin
        if (bus_addr_ok) begin
          if (bus_data_ok) begin
            instDone  = 1'b1;
            stateNext = IDLE;
          end else begin
            stateNext = I_DATA;
          end
        end
      end
      I_DATA: begin
        if (bus_data_ok) begin
          instDone  = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign bus_req   = (state == D_ADDR) | (state == I_ADDR);
  assign bus_wr    = req.wr;
  assign bus_size  = req.size;
  assign bus_addr  = req.addr;
  assign bus_wdata = req.wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      req          <= '0;
      maskI        <= 1'b0;
      maskD        <= 1'b0;
      inst_rdata   <= '0;
      data_rdata   <= '0;
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      stall_o      <= 1'b0;
    end else begin
      state        <= stateNext;
      req          <= reqNext;
      // mask hides the served requester's stale req for one cycle
      maskI        <= instDone;
      maskD        <= dataDone;
      inst_data_ok <= instDone;
      data_data_ok <= dataDone;
      if (instDone) inst_rdata <= bus_rdata;
      if (dataDone) data_rdata <= bus_rdata;
      stall_o <= (inst_req & ~instDone)
               | (data_req & ~dataDone);
    end
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one SRAM-like memory bus between the fetch-side requester (inst) and the MEM-stage requester (data).
- Allows exactly one outstanding transaction. Data side wins on simultaneous requests.
- Sits between the pipeline (IF fetch, MEM stage driven by memenM/memwriteM) and the bus bridge.
- Drives a pipeline stall request that the hazard unit fans out to the stallE/stallM/stallW inputs.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
inst_req  in  1  fetch request, held high until inst_data_ok
inst_addr  in  ADDR_W  fetch address, stable while inst_req
inst_rdata  out  DATA_W  fetched word, valid when inst_data_ok
inst_data_ok  out  1  one-cycle completion pulse for fetch
data_req  in  1  data request, held high until data_data_ok
data_wr  in  1  1 = store, 0 = load
data_size  in  2  0 byte, 1 half, 2 word
data_addr  in  ADDR_W  data address
data_wdata  in  DATA_W  store data
data_rdata  out  DATA_W  load data, valid when data_data_ok
data_data_ok  out  1  one-cycle completion pulse for data
bus_req  out  1  bus request
bus_wr  out  1  bus write
bus_size  out  2  bus size
bus_addr  out  ADDR_W  bus address
bus_wdata  out  DATA_W  bus write data
bus_addr_ok  in  1  bus accepted request (handshake with bus_req)
bus_data_ok  in  1  bus response valid
bus_rdata  in  DATA_W  bus read data
stall_o  out  1  pipeline stall request

Behaviour:
- FSM states:
  - IDLE
  - D_ADDR: data address phase
  - D_DATA: data response wait
  - I_ADDR: fetch address phase
  - I_DATA: fetch response wait
- Reset (async, rst=1):
  - State goes to IDLE; mask register cleared.
  - All outputs 0: bus_req, bus_wr, bus_size, bus_addr, bus_wdata, inst_rdata, data_rdata, inst_data_ok, data_data_ok, stall_o.
- Reset mid-transaction: same as above. Any bus_addr_ok/bus_data_ok arriving after reset while in IDLE is ignored.
- IDLE:
  - Eligible data = data_req & ~mask_d. Eligible inst = inst_req & ~mask_i.
  - Eligible data: latch wr/size/addr/wdata into request registers, go D_ADDR.
  - Else eligible inst: latch addr with wr=0, size=2, go I_ADDR.
  - Else stay. bus_req=0 in IDLE.
- x_ADDR:
  - bus_req=1; bus_* are driven from the request registers and stay stable until accepted.
  - bus_addr_ok=1: go x_DATA. If bus_data_ok is also 1 in that same cycle, complete immediately (see completion).
- x_DATA:
  - bus_req=0.
  - bus_data_ok=1: complete.
- Completion:
  - Register bus_rdata into inst_rdata or data_rdata. The rdata register holds its value until the next completion on that side.
  - Pulse inst_data_ok or data_data_ok for exactly 1 cycle; the pulse coincides with the next cycle in IDLE.
  - Go IDLE and set the mask bit of the served side (mask_i or mask_d) for that one cycle. The requester's stale req is therefore not re-granted.
  - The other side may be granted in that same IDLE cycle.
- Latency:
  - With zero-wait bus (addr_ok in the first x_ADDR cycle, data_ok one cycle later), req to data_ok is 3 cycles (IDLE→x_ADDR→x_DATA→pulse).
- Store completion: data_rdata is still written with bus_rdata, whose value is don't-care for stores.
- bus_data_ok outside x_ADDR/x_DATA: ignored.
- Arbitration:
  - Fixed priority data > inst when evaluated in IDLE.
  - A granted fetch is never preempted; a data request arriving during it waits for IDLE.
- stall_o (registered): next value = (inst_req & ~inst_data_ok_next) | (data_req & ~data_data_ok_next).
  - Effect: deasserts in the same cycle as the last pending completion pulse.
  - Stays 0 when neither side requests.
- Widths: no arithmetic; all fields pass through unmodified.

Test Plan:
- Reset hold then release, no requests → all outputs 0 and stall_o=0 for 10 cycles; assert rst while in D_DATA → state IDLE and outputs 0 immediately (async), a late bus_data_ok is ignored.
- Single fetch, inst_addr=0xBFC00000, addr_ok in cycle 1, data_ok with rdata=0x3C080001 one cycle later → inst_data_ok one-cycle pulse at cycle 3, inst_rdata=0x3C080001, bus_wr=0, bus_size=2.
- Simultaneous inst_req and data_req (load, addr=0x80001000, size=2) → data served first, then inst granted in the IDLE cycle carrying the data_data_ok pulse; data_rdata/inst_rdata correct; stall_o high throughout, low in the inst_data_ok cycle.
- Store byte data_wr=1, size=0, addr=0x80000003, wdata=0x000000AB, with bus_addr_ok delayed 4 cycles → bus_req and bus_* fields held stable for all 5 cycles, then data_data_ok pulses once.
- Bus asserts addr_ok and data_ok in the same cycle → completion pulse in the next cycle, no x_DATA visit.
- Requester keeps req high one cycle after its data_ok → no duplicate grant (mask check); a genuinely new req the following cycle is granted.
